wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone (classic, 32-bit) arbiter that shares one slave port between two masters.
- Intended use: the LM32 instruction bus (m0) and LM32 data bus (m1) share one memory/peripheral path (BRAM or DDR controller port) inside system.
- Round-robin grant, held for the full bus cycle (cyc); slave outputs muxed from the granted master; ack/err routed back to that master only.

Parameters:
- AW, 32, address width
- DW, 32, data width (sel width = DW/8)
- TIMEOUT, 255, stall cycles before forced error; used only with WB_ARB_TIMEOUT_EN

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_adr, m1_adr  in  AW  master address
- m0_dat_w, m1_dat_w  in  DW  master write data
- m0_sel, m1_sel  in  DW/8  byte selects
- m0_we, m0_cyc, m0_stb / m1_we, m1_cyc, m1_stb  in  1 each  master control
- m0_dat_r, m1_dat_r  out  DW  read data (both driven from s_dat_r)
- m0_ack, m0_err / m1_ack, m1_err  out  1 each  termination to master
- s_adr  out  AW;  s_dat_w  out  DW;  s_sel  out  DW/8;  s_we, s_cyc, s_stb  out  1 each  slave request
- s_dat_r  in  DW;  s_ack, s_err  in  1 each  slave response
- gnt  out  2  one-hot current grant (bit0 = m0), debug/LED visibility

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - state=IDLE, last=1 (so m0 wins the first contention), gnt=00.
  - s_cyc=s_stb=0; all m*_ack/m*_err=0.
  - Any in-flight cycle is abandoned.
- States: IDLE, GNT0, GNT1 (registered).
- IDLE:
  - only m0_cyc -> GNT0; only m1_cyc -> GNT1.
  - both -> grant the master != last.
  - none -> stay in IDLE.
- Arbitration latency: request in cycle N, gnt and s_cyc asserted in cycle N+1.
- GNTx: held while mx_cyc=1, covering multi-beat/burst cycles with stb gaps.
  - When mx_cyc=0 at a clock edge: -> IDLE, last<=x, gnt<=00.
  - Exactly one idle bus cycle between successive grants.
- Datapath: combinational from the state register.
  - s_adr, s_dat_w, s_sel, s_we come from the granted master, else 0.
  - s_cyc = granted mx_cyc; s_stb = granted mx_stb.
  - In IDLE, s_cyc=s_stb=0.
- Termination:
  - mx_ack = s_ack & gnt[x]; mx_err = s_err & gnt[x].
  - The non-granted master always sees ack=err=0.
  - m0_dat_r = m1_dat_r = s_dat_r.
- Ack latency: zero added cycles; slave ack passes through in the same cycle.
- Master drops cyc in the same cycle as ack: legal. The grant releases at that edge.
- Master drops cyc before any ack (abort): release as above. A late s_ack arriving in IDLE is discarded.
- Starvation: a master holding cyc indefinitely keeps the grant (Wishbone semantics). Use the optional feature to bound stalls.
- Simultaneous release of m0 and new request from m1: m1 is granted in the cycle after IDLE.

Optional Feature:
- WB_ARB_TIMEOUT_EN defined:
  - Counter cnt (width clog2(TIMEOUT+1)) increments each cycle with s_stb=1 and s_ack=s_err=0; it clears on ack, err or leaving GNTx.
  - When cnt==TIMEOUT: pulse mx_err=1 for one cycle to the granted master, force s_cyc=s_stb=0 that cycle, and clear cnt.
  - The grant persists until the master drops cyc.
- Not defined:
  - No counter; TIMEOUT is ignored.
  - Arbiter waits forever for s_ack/s_err.
  - err is a pure pass-through.

Test Plan:
- Reset held 3 cycles, then released, with both cyc=0 -> gnt=00, s_cyc=0, all acks 0.
- m0 read adr=0x00000100, slave acks 1 cycle after s_stb, s_dat_r=0xDEADBEEF:
  - gnt=01 at N+1.
  - m0_ack=1 with m0_dat_r=0xDEADBEEF.
  - m1_ack=0 throughout.
- m0 and m1 assert cyc in the same cycle after reset:
  - m0 served first (gnt=01).
  - After m0 drops cyc: one IDLE cycle, then gnt=10.
  - m1 write adr=0x20000000, dat=0x000000A5, sel=4'hF appears on s_*.
- Repeated contention, four back-to-back pairs -> grant order m0, m1, m0, m1; no master is served twice in a row.
- m1 four-beat burst with cyc held high and stb low in beat 3:
  - Grant stays 10 for all four acks.
  - m0 request during the burst is delayed until m1 cyc=0.
- With WB_ARB_TIMEOUT_EN, TIMEOUT=8, slave never acks:
  - m0_err pulses once, exactly 8 stall cycles after s_stb rose.
  - s_stb=0 that cycle.
- Without WB_ARB_TIMEOUT_EN: no err; the cycle stays pending.

Source files
------------

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant held for the whole cyc.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_w,
  input  logic [DW/8-1:0] m0_sel,
  input  logic            m0_we,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  output logic [DW-1:0]   m0_dat_r,
  output logic            m0_ack,
  output logic            m0_err,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_w,
  input  logic [DW/8-1:0] m1_sel,
  input  logic            m1_we,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  output logic [DW-1:0]   m1_dat_r,
  output logic            m1_ack,
  output logic            m1_err,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_w,
  output logic [DW/8-1:0] s_sel,
  output logic            s_we,
  output logic            s_cyc,
  output logic            s_stb,
  input  logic [DW-1:0]   s_dat_r,
  input  logic            s_ack,
  input  logic            s_err,
  output logic [1:0]      gnt
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;
  logic   g0, g1;
  logic   tmo;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // last holds the index of the most recently served master; the other one wins a tie
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_nxt = last ? GNT0 : GNT1;
        else if (m0_cyc)      state_nxt = GNT0;
        else if (m1_cyc)      state_nxt = GNT1;
      end
      GNT0: if (!m0_cyc) begin
        state_nxt = IDLE;
        last_nxt  = 1'b0;
      end
      GNT1: if (!m1_cyc) begin
        state_nxt = IDLE;
        last_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign g0  = (state == GNT0);
  assign g1  = (state == GNT1);
  assign gnt = {g1, g0};

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] cnt;

  assign tmo = (state != IDLE) && (cnt == CW'(TIMEOUT));

  // counts stalled strobe cycles; any termination or grant change restarts it
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (state == IDLE || state_nxt != state || tmo || s_ack || s_err)
      cnt <= '0;
    else if (s_stb)
      cnt <= cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_we    = 1'b0;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    case (state)
      GNT0: begin
        s_adr   = m0_adr;
        s_dat_w = m0_dat_w;
        s_sel   = m0_sel;
        s_we    = m0_we;
        s_cyc   = m0_cyc & ~tmo;
        s_stb   = m0_stb & ~tmo;
      end
      GNT1: begin
        s_adr   = m1_adr;
        s_dat_w = m1_dat_w;
        s_sel   = m1_sel;
        s_we    = m1_we;
        s_cyc   = m1_cyc & ~tmo;
        s_stb   = m1_stb & ~tmo;
      end
      default: ;
    endcase
  end

  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;
  assign m0_ack   = s_ack & g0;
  assign m1_ack   = s_ack & g1;
  assign m0_err   = (s_err | tmo) & g0;
  assign m1_err   = (s_err | tmo) & g1;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Scoreboard bench for wb_arbiter2: a registered-ack slave model plus two master tasks.
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_adr, m1_adr, m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
  logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb, s_ack, s_err;
  logic [1:0]  gnt;
  logic        slave_en;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        m;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  wb_arbiter2 #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_we(m0_we),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_we(m1_we),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_we(s_we), .s_cyc(s_cyc), .s_stb(s_stb),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err), .gnt(gnt)
  );

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : ~a;
  endfunction

  // slave acks one cycle after it sees a strobe
  assign s_err = 1'b0;
  always @(posedge clk) begin
    if (reset) s_ack <= 1'b0;
    else begin
      s_ack   <= slave_en & s_cyc & s_stb & ~s_ack;
      s_dat_r <= rd_model(s_adr);
    end
  end

  // every ack is matched against the next expected transfer
  always @(negedge clk) begin
    if (!reset && (m0_ack || m1_ack)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: ack m0=%b m1=%b with nothing expected", m0_ack, m1_ack);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ((m0_ack && m1_ack) || (m1_ack !== e.m) || (s_adr !== e.adr) || (s_we !== e.we) ||
            (!e.we && ((e.m ? m1_dat_r : m0_dat_r) !== e.dat)) ||
            (e.we && ((s_dat_w !== e.dat) || (s_sel !== 4'hF)))) begin
          errors++;
          $display("FAIL sb_xfer: got ack0=%b ack1=%b adr=%h we=%b dr0=%h dr1=%h dw=%h sel=%h want m%0d adr=%h we=%b dat=%h",
                   m0_ack, m1_ack, s_adr, s_we, m0_dat_r, m1_dat_r, s_dat_w, s_sel, e.m, e.adr, e.we, e.dat);
        end
      end
    end
  end

  function automatic exp_t mk(input logic m, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    exp_t e;
    e.m = m; e.we = we; e.adr = adr; e.dat = we ? dat : rd_model(adr);
    return e;
  endfunction

  task automatic master_cyc(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    logic got;
    if (m == 0) begin
      m0_adr = adr; m0_dat_w = dat; m0_we = we; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
    end else begin
      m1_adr = adr; m1_dat_w = dat; m1_we = we; m1_sel = 4'hF; m1_cyc = 1'b1; m1_stb = 1'b1;
    end
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = (m == 0) ? m0_ack : m1_ack;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_wait m%0d: got no ack want ack within 60 cycles", m);
    end
    @(posedge clk); #1;
    if (m == 0) begin m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; end
    else        begin m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin errors++; $display("FAIL reset_scyc: got cyc=%b stb=%b want 0 0", s_cyc, s_stb); end
    checks++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin
      errors++; $display("FAIL reset_term: got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err});
    end
  endtask

  task automatic test_single_read();
    @(posedge clk); #1;
    sb.push_back(mk(1'b0, 1'b0, 32'h0000_0100, 32'h0));
    fork
      master_cyc(0, 1'b0, 32'h0000_0100, 32'h0);
      begin
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00) begin errors++; $display("FAIL lat_n: got gnt=%b want 00", gnt); end
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01 || s_cyc !== 1'b1 || s_stb !== 1'b1) begin
          errors++; $display("FAIL lat_n1: got gnt=%b cyc=%b stb=%b want 01 1 1", gnt, s_cyc, s_stb);
        end
      end
    join
  endtask

  task automatic test_contention();
    do_reset();
    @(posedge clk); #1;
    sb.push_back(mk(1'b0, 1'b0, 32'h0000_0200, 32'h0));
    sb.push_back(mk(1'b1, 1'b1, 32'h2000_0000, 32'h0000_00A5));
    fork
      master_cyc(0, 1'b0, 32'h0000_0200, 32'h0);
      master_cyc(1, 1'b1, 32'h2000_0000, 32'h0000_00A5);
      begin
        int k;
        k = 0;
        while (k < 60 && gnt !== 2'b01) begin @(negedge clk); k++; end
        while (k < 60 && gnt === 2'b01) begin @(negedge clk); k++; end
        checks++;
        if (gnt !== 2'b00) begin errors++; $display("FAIL idle_gap: got gnt=%b want 00", gnt); end
        @(negedge clk);
        checks++;
        if (gnt !== 2'b10) begin errors++; $display("FAIL second_gnt: got gnt=%b want 10", gnt); end
      end
    join
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(1'b0, 1'b0, 32'h0000_1000 + 32'(i * 16), 32'h0));
      sb.push_back(mk(1'b1, 1'b1, 32'h0000_2000 + 32'(i * 16), 32'h1111_0000 + 32'(i)));
    end
    fork
      for (int i = 0; i < 4; i++) begin
        master_cyc(0, 1'b0, 32'h0000_1000 + 32'(i * 16), 32'h0);
        @(posedge clk); #1;
      end
      for (int j = 0; j < 4; j++) begin
        master_cyc(1, 1'b1, 32'h0000_2000 + 32'(j * 16), 32'h1111_0000 + 32'(j));
        @(posedge clk); #1;
      end
    join
  endtask

  task automatic test_burst();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) sb.push_back(mk(1'b1, 1'b0, 32'h4000_0000 + 32'(i * 4), 32'h0));
    sb.push_back(mk(1'b0, 1'b0, 32'h0000_0500, 32'h0));
    fork
      begin
        m1_adr = 32'h4000_0000; m1_sel = 4'hF; m1_we = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (i == 2) begin
            m1_stb = 1'b0;
            @(posedge clk); #1;
            m1_stb = 1'b1;
          end
          for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (m1_ack) break;
          end
          checks++;
          if (m1_ack !== 1'b1 || gnt !== 2'b10) begin
            errors++; $display("FAIL burst_beat%0d: got ack=%b gnt=%b want 1 10", i, m1_ack, gnt);
          end
          @(posedge clk); #1;
          if (i < 3) m1_adr = 32'h4000_0000 + 32'((i + 1) * 4);
        end
        m1_cyc = 1'b0; m1_stb = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 master_cyc(0, 1'b0, 32'h0000_0500, 32'h0);
      end
    join
  endtask

  task automatic test_timeout();
    int errs, first, k0;
    logic stb_at_err;
    errs = 0; first = -1; stb_at_err = 1'bx;
    slave_en = 1'b0;
    @(posedge clk); #1;
    m0_adr = 32'h0000_0300; m0_sel = 4'hF; m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    k0 = 0;
    while (k0 < 10 && s_stb !== 1'b1) begin @(negedge clk); k0++; end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (m0_err === 1'b1) begin
        errs++;
        if (first < 0) begin first = k; stb_at_err = s_stb; end
      end
      if (m1_err !== 1'b0) errs += 100;
    end
`ifdef WB_ARB_TIMEOUT_EN
    checks++;
    if (errs != 1 || first != 8) begin
      errors++; $display("FAIL tmo_err: got count=%0d at=%0d want 1 at 8", errs, first);
    end
    checks++;
    if (stb_at_err !== 1'b0) begin errors++; $display("FAIL tmo_stb: got s_stb=%b want 0", stb_at_err); end
`else
    checks++;
    if (errs != 0) begin errors++; $display("FAIL no_tmo_err: got count=%0d want 0", errs); end
    checks++;
    if (s_cyc !== 1'b1 || gnt !== 2'b01) begin
      errors++; $display("FAIL no_tmo_pend: got cyc=%b gnt=%b want 1 01", s_cyc, gnt);
    end
`endif
    // abort without ack: grant must release
    @(posedge clk); #1;
    m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0) begin
      errors++; $display("FAIL abort_rel: got gnt=%b cyc=%b want 00 0", gnt, s_cyc);
    end
    slave_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; slave_en = 1'b1;
    m0_adr = '0; m0_dat_w = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_adr = '0; m1_dat_w = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_burst();
    test_timeout();
    repeat (4) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_left: got %0d pending want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
